irda_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one IrDA transmitter between NUM_REQ byte sources. Sits between the requesters and the transmitter controller: selects a winner, loads its byte onto the transmit data bus, issues a one-cycle start, waits for frame done, then enforces an inter-frame guard gap before the next arbitration.

---
 rtl/irda_pkg.sv | 15 +
 rtl/irda_rr_pick.sv | 30 +++
 rtl/irda_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_irda_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irda_pkg.sv
// Shared types and default constants for the IrDA transmit arbiter.
package irda_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StGap
  } state_e;

  localparam int unsigned DefDataW         = 8;
  localparam int unsigned DefGapCycles     = 16;
  localparam int unsigned DefTimeoutCycles = 65536;

endpackage

// File: rtl/irda_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module irda_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [PTR_W-1:0]   o_index
);

  int unsigned      w_j;
  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_j     = 0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_j    = (int'(i_ptr) + i) % NUM_REQ;
      w_cand = PTR_W'(w_j);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/irda_tx_arbiter.sv
// Round-robin scheduler sharing one IrDA transmitter among NUM_REQ byte sources.
// Optional WAIT watchdog enabled by defining IRDA_TX_ARB_TIMEOUT_EN.
module irda_tx_arbiter
  import irda_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned GAP_CYCLES     = DefGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ena,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_in,
  input  logic                      i_tx_done,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_start,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [NUM_REQ-1:0]        o_sent,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e              r_state, w_state_d;
  logic [PtrW-1:0]     r_ptr, w_ptr_d;
  logic [PtrW-1:0]     r_owner, w_owner_d;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_d;
  logic                r_tx_start, w_tx_start_d;
  logic [NUM_REQ-1:0]  r_grant, w_grant_d;
  logic [NUM_REQ-1:0]  r_sent, w_sent_d;
  logic                r_busy, w_busy_d;
  logic                r_err, w_err_d;
  logic [GapW-1:0]     r_gap_cnt, w_gap_cnt_d;
  logic                w_finish;
  logic                w_pick_valid;
  logic [PtrW-1:0]     w_pick_idx;
  logic [DATA_W-1:0]   w_pick_data;

`ifdef IRDA_TX_ARB_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [ToW-1:0] r_to_cnt, w_to_cnt_d;
`endif

  irda_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PtrW)
  ) u_pick (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_valid(w_pick_valid),
    .o_index(w_pick_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == PtrW'(i)) w_pick_data = i_data_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_owner_d    = r_owner;
    w_tx_data_d  = r_tx_data;
    w_tx_start_d = 1'b0;
    w_grant_d    = '0;
    w_sent_d     = '0;
    w_err_d      = 1'b0;
    w_gap_cnt_d  = r_gap_cnt;
    w_finish     = 1'b0;
`ifdef IRDA_TX_ARB_TIMEOUT_EN
    w_to_cnt_d   = r_to_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_ena && w_pick_valid) begin
          w_state_d    = StStart;
          w_owner_d    = w_pick_idx;
          w_tx_data_d  = w_pick_data;
          w_tx_start_d = 1'b1;
          w_grant_d    = NUM_REQ'(1) << w_pick_idx;
        end
      end
      StStart: begin
        w_state_d = StWait;
`ifdef IRDA_TX_ARB_TIMEOUT_EN
        w_to_cnt_d = '0;
`endif
      end
      StWait: begin
        // tx_done beats a watchdog expiry on the same edge
        if (i_tx_done) begin
          w_sent_d = NUM_REQ'(1) << r_owner;
          w_finish = 1'b1;
        end
`ifdef IRDA_TX_ARB_TIMEOUT_EN
        else if (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
          w_err_d  = 1'b1;
          w_finish = 1'b1;
        end else begin
          w_to_cnt_d = r_to_cnt + ToW'(1);
        end
`endif
      end
      StGap: begin
        if (r_gap_cnt == '0) w_state_d = StIdle;
        else                 w_gap_cnt_d = r_gap_cnt - GapW'(1);
      end
      default: w_state_d = StIdle;
    endcase
    if (w_finish) begin
      w_ptr_d = (r_owner == PtrW'(NUM_REQ - 1)) ? '0 : r_owner + PtrW'(1);
      if (GAP_CYCLES == 0) begin
        w_state_d = StIdle;
      end else begin
        w_state_d   = StGap;
        w_gap_cnt_d = GapW'(GAP_CYCLES - 1);
      end
    end
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_grant    <= '0;
      r_sent     <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_gap_cnt  <= '0;
`ifdef IRDA_TX_ARB_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_owner    <= w_owner_d;
      r_tx_data  <= w_tx_data_d;
      r_tx_start <= w_tx_start_d;
      r_grant    <= w_grant_d;
      r_sent     <= w_sent_d;
      r_busy     <= w_busy_d;
      r_err      <= w_err_d;
      r_gap_cnt  <= w_gap_cnt_d;
`ifdef IRDA_TX_ARB_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_d;
`endif
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_grant    = r_grant;
  assign o_sent     = r_sent;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_irda_tx_arbiter.sv
// Self-checking bench for irda_tx_arbiter; covers the watchdog when IRDA_TX_ARB_TIMEOUT_EN is set.
module tb_irda_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 16;
`ifdef IRDA_TX_ARB_TIMEOUT_EN
  localparam int T = 32;
`else
  localparam int T = 65536;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [W-1:0]   o_tx_data;
  logic           o_tx_start, o_busy, o_err;
  logic [N-1:0]   o_grant, o_sent;

  int checks = 0;
  int failures = 0;

  irda_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_W        (W),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ena     (ena),
    .i_req     (req),
    .i_data_in (data_in),
    .i_tx_done (tx_done),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_grant   (o_grant),
    .o_sent    (o_sent),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timestamp model: k counts active clock edges; a frame captured at edge s may
  // complete from edge s+2, and the arbiter may rearbitrate after edge done+G.
  int           k = 0;
  bit           m_active = 0;
  int           m_start_edge = 0;
  int           m_idle_at = -1;
  int           m_ptr = 0;
  int           m_owner = 0;
  logic [W-1:0] e_tx_data = '0;
  logic         e_start = 0, e_busy = 0, e_err = 0;
  logic [N-1:0] e_grant = '0, e_sent = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_idle_at = -1; m_ptr = 0; m_owner = 0;
      e_tx_data = '0; e_start = 0; e_busy = 0; e_err = 0; e_grant = '0; e_sent = '0;
    end else begin
      bit fin, ok;
      int w;
      k++;
      e_start = 0; e_grant = '0; e_sent = '0; e_err = 0;
      fin = 0; ok = 0;
      if (m_active) begin
        if (k >= m_start_edge + 2 && tx_done) begin fin = 1; ok = 1; end
`ifdef IRDA_TX_ARB_TIMEOUT_EN
        else if (k == m_start_edge + 1 + T) fin = 1;
`endif
        if (fin) begin
          m_active = 0;
          m_ptr = (m_owner + 1) % N;
          m_idle_at = k + G;
          if (ok) e_sent = N'(1) << m_owner;
          else    e_err = 1;
        end
      end else if (k > m_idle_at && ena && req != '0) begin
        w = -1;
        for (int i = 0; i < N; i++) if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        m_owner = w;
        e_tx_data = data_in[w*W +: W];
        e_start = 1;
        e_grant = N'(1) << w;
        m_active = 1;
        m_start_edge = k;
      end
      e_busy = m_active || (k < m_idle_at);
    end
  end

  always @(negedge clk) begin
    check("tx_data", 64'(o_tx_data), 64'(e_tx_data));
    check("tx_start", 64'(o_tx_start), 64'(e_start));
    check("grant", 64'(o_grant), 64'(e_grant));
    check("sent", 64'(o_sent), 64'(e_sent));
    check("busy", 64'(o_busy), 64'(e_busy));
    check("err", 64'(o_err), 64'(e_err));
  end

  task automatic wait_start(output int idx, output int at);
    bit seen = 0;
    idx = -1;
    at = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (o_tx_start) begin
        seen = 1;
        at = k;
        for (int i = 0; i < N; i++) if (o_grant[i]) idx = i;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_start timeout actual=no_start required=start");
    end
  endtask

  task automatic send_done(input int lat);
    repeat (lat) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (o_busy && c < 100) begin c++; @(negedge clk); end
    if (o_busy) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int idx, at, prev, k0, cnt;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    check("reset_outputs", {o_tx_data, o_tx_start, o_grant, o_sent, o_busy, o_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    // All sources held: rotation 0,1,2,3,0 with guard spacing
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    prev = 0;
    for (int f = 0; f < 5; f++) begin
      wait_start(idx, at);
      check("rr_order", 64'(idx), 64'(exp_order[f]));
      if (f > 0) check("start_spacing_ge18", 64'(at - prev >= 18), 64'd1);
      prev = at;
      send_done(2);
    end
    req = '0;
    wait_idle();

    // ptr is now 1: source 3 ahead of source 0
    req = 4'b1001;
    wait_start(idx, at);
    check("wrap_winner", 64'(idx), 64'd3);
    req = '0;
    send_done(1);
    wait_idle();

    // Single source with a known byte, then the guard gap length
    data_in = {8'h44, 8'h33, 8'hA5, 8'h11};
    req = 4'b0010;
    wait_start(idx, at);
    check("single_capture", {o_tx_data, o_grant, o_tx_start}, {8'hA5, 4'b0010, 1'b1});
    req = '0;
    send_done(3);
    check("single_sent", 64'(o_sent), 64'(4'b0010));
    cnt = 0;
    while (o_busy && cnt < 100) begin cnt++; @(negedge clk); end
    check("gap_len", 64'(cnt), 64'd16);

    // ena gating
    ena = 1'b0;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("ena_low_hold", {o_busy, o_grant}, 64'd0);
    ena = 1'b1;
    k0 = k;
    wait_start(idx, at);
    check("ena_latency", 64'(at - k0), 64'd1);
    req = '0;
    ena = 1'b0;
    send_done(4);
    check("ena_drop_sent", 64'(o_sent), 64'(4'b0001));
    wait_idle();
    ena = 1'b1;

    // Reset mid-WAIT
    req = 4'b0100;
    wait_start(idx, at);
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midframe_reset", {o_tx_data, o_tx_start, o_grant, o_sent, o_busy, o_err}, 64'd0);
    @(negedge clk);
    check("reset_no_sent", 64'(o_sent), 64'd0);
    rst_n = 1'b1;
    req = 4'b1001;
    wait_start(idx, at);
    check("post_reset_ptr0", 64'(idx), 64'd0);
    req = '0;
    send_done(1);
    wait_idle();

`ifdef IRDA_TX_ARB_TIMEOUT_EN
    // Watchdog: no tx_done, err after T cycles in WAIT, next grant to owner+1
    req = 4'b0110;
    wait_start(idx, at);
    check("to_owner", 64'(idx), 64'd1);
    cnt = 0;
    while (!o_err && cnt < 200) begin cnt++; @(negedge clk); end
    check("to_err_delay", 64'(cnt), 64'(T + 1));
    wait_start(idx, at);
    check("to_next_owner", 64'(idx), 64'd2);
    req = '0;
    send_done(1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
